// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper: state encodings, BCD ceiling,
// pending-point width and the streak-to-multiplier mapping.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [15:0] BCD_MAX = 16'h9999;
  localparam int unsigned PEND_W  = 8;

  // min(1 + streak/step, max_mult); the parameters are constants at every call site.
  function automatic logic [2:0] mult_of(input logic [7:0] streak_v,
                                         input int unsigned step_v,
                                         input int unsigned max_v);
    int unsigned raw_v;
    raw_v = 32'd1 + (32'(streak_v) / step_v);
    if (raw_v > max_v) begin
      mult_of = 3'(max_v);
    end else begin
      mult_of = 3'(raw_v);
    end
  endfunction

endpackage

// File: rtl/score_keeper_bcd_inc4.sv
// Combinational saturating 4-digit BCD increment (holds at 9999).
// Shared with the on-screen score renderer.
module bcd_inc4
  import score_keeper_pkg::*;
(
  input  logic [15:0] bcd_i,
  output logic [15:0] bcd_o
);

  logic [15:0] sum_s;
  logic        carry_s;

  // Ripple a +1 through the digits, wrapping each 9 to 0.
  always_comb begin
    sum_s   = bcd_i;
    carry_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry_s) begin
        if (bcd_i[4*i +: 4] == 4'd9) begin
          sum_s[4*i +: 4] = 4'd0;
          carry_s         = 1'b1;
        end else begin
          sum_s[4*i +: 4] = bcd_i[4*i +: 4] + 4'd1;
          carry_s         = 1'b0;
        end
      end else begin
        sum_s[4*i +: 4] = bcd_i[4*i +: 4];
      end
    end
    if (bcd_i == BCD_MAX) begin
      bcd_o = BCD_MAX;
    end else begin
      bcd_o = sum_s;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: saturating BCD score, hit streak and multiplier, draining pending points one per clock.
// Optional high-score tracking is enabled by defining SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned POINTS_PER_HIT = 1,
  parameter int unsigned STREAK_STEP    = 4,
  parameter int unsigned MAX_MULT       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        changeScore,
  input  logic        addScore,
  input  logic        songDone,
  output logic [15:0] scoreBCD,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier,
  output logic        busy,
  output logic        scoreFinal,
  output logic [15:0] highScoreBCD
);

  localparam logic [PEND_W-1:0] PPH      = PEND_W'(POINTS_PER_HIT);
  localparam logic [PEND_W-1:0] PEND_MAX = 8'd255;

  state_e            state_q,   state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ended_q,   ended_d;
  logic [15:0]       score_q,   score_d;
  logic [7:0]        streak_q,  streak_d;
  logic [2:0]        mult_q,    mult_d;
  logic              busy_q,    busy_d;
  logic              final_q,   final_d;

  logic              hit_s, miss_s, drain_s;
  logic [PEND_W-1:0] pts_s;
  logic [PEND_W:0]   pend_sum_s;
  logic [15:0]       score_inc_s;

  bcd_inc4 u_inc (
    .bcd_i (score_q),
    .bcd_o (score_inc_s)
  );

  assign hit_s   = changeScore &  addScore & ~ended_q;
  assign miss_s  = changeScore & ~addScore & ~ended_q;
  assign drain_s = (state_q == COUNT) && (pending_q != 8'd0);
  assign pts_s   = {5'd0, mult_q} * PPH;

  // Next-state: start overrides everything; otherwise a hit and a drain may share one edge.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ended_d    = ended_q;
    score_d    = score_q;
    streak_d   = streak_q;
    mult_d     = mult_q;
    busy_d     = busy_q;
    final_d    = final_q;
    pend_sum_s = {1'b0, pending_q};
    if (start) begin
      state_d   = IDLE;
      pending_d = 8'd0;
      ended_d   = 1'b0;
      score_d   = 16'd0;
      streak_d  = 8'd0;
      mult_d    = 3'd1;
      busy_d    = 1'b0;
      final_d   = 1'b0;
    end else begin
      if (songDone) begin
        ended_d = 1'b1;
      end else begin
        ended_d = ended_q;
      end

      if (hit_s) begin
        streak_d = (streak_q == 8'd255) ? 8'd255 : streak_q + 8'd1;
      end else if (miss_s) begin
        streak_d = 8'd0;
      end else begin
        streak_d = streak_q;
      end
      mult_d = mult_of(streak_d, STREAK_STEP, MAX_MULT);

      pend_sum_s = {1'b0, pending_q}
                 + {1'b0, (hit_s ? pts_s : 8'd0)}
                 - {8'd0, drain_s};
      if (pend_sum_s > {1'b0, PEND_MAX}) begin
        pending_d = PEND_MAX;
      end else begin
        pending_d = pend_sum_s[PEND_W-1:0];
      end

      if (drain_s) begin
        score_d = score_inc_s;
      end else begin
        score_d = score_q;
      end

      case (state_q)
        IDLE: begin
          if (ended_q) begin
            state_d = FINAL;
            final_d = 1'b1;
          end else if (pending_d != 8'd0) begin
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
        COUNT: begin
          if (pending_d == 8'd0) begin
            state_d = IDLE;
          end else begin
            state_d = COUNT;
          end
        end
        FINAL: begin
          state_d = FINAL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      busy_d = (pending_d != 8'd0);
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 8'd0;
      ended_q   <= 1'b0;
      score_q   <= 16'd0;
      streak_q  <= 8'd0;
      mult_q    <= 3'd1;
      busy_q    <= 1'b0;
      final_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ended_q   <= ended_d;
      score_q   <= score_d;
      streak_q  <= streak_d;
      mult_q    <= mult_d;
      busy_q    <= busy_d;
      final_q   <= final_d;
    end
  end

  assign scoreBCD   = score_q;
  assign streak     = streak_q;
  assign multiplier = mult_q;
  assign busy       = busy_q;
  assign scoreFinal = final_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [15:0] high_q, high_d;

  // Capture a new best on the IDLE->FINAL transition; BCD orders like plain unsigned.
  always_comb begin
    high_d = high_q;
    if (!start && (state_q == IDLE) && ended_q && (score_q > high_q)) begin
      high_d = score_q;
    end else begin
      high_d = high_q;
    end
  end

  // High-score register survives start; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_q <= 16'd0;
    end else begin
      high_q <= high_d;
    end
  end

  assign highScoreBCD = high_q;
`else
  assign highScoreBCD = 16'd0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper (default parameters).
module tb_score_keeper;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        changeScore = 1'b0;
  logic        addScore = 1'b0;
  logic        songDone = 1'b0;
  logic [15:0] scoreBCD;
  logic [7:0]  streak;
  logic [2:0]  multiplier;
  logic        busy;
  logic        scoreFinal;
  logic [15:0] highScoreBCD;

  int n_tests = 0;
  int n_fail  = 0;

  score_keeper dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .changeScore  (changeScore),
    .addScore     (addScore),
    .songDone     (songDone),
    .scoreBCD     (scoreBCD),
    .streak       (streak),
    .multiplier   (multiplier),
    .busy         (busy),
    .scoreFinal   (scoreFinal),
    .highScoreBCD (highScoreBCD)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic add);
    changeScore = 1'b1;
    addScore    = add;
    step();
    changeScore = 1'b0;
    addScore    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_song();
    songDone = 1'b1;
    step();
    songDone = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    chk(tag, 16'(busy), 16'd0);
  endtask

  task automatic wait_final(input string tag, input int budget);
    int k;
    k = 0;
    while (!scoreFinal && k < budget) begin
      step();
      k++;
    end
    chk(tag, 16'(scoreFinal), 16'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score"}, scoreBCD, 16'h0000);
    chk({tag, "_streak"}, 16'(streak), 16'd0);
    chk({tag, "_mult"}, 16'(multiplier), 16'd1);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_final"}, 16'(scoreFinal), 16'd0);
    chk({tag, "_high"}, highScoreBCD, 16'h0000);
  endtask

  logic [15:0] high_exp;

  initial begin
    // Reset state
    repeat (2) step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // Five spaced hits: multipliers 1,1,1,1,2 -> 6 points; first one checks latency
    do_start();
    beat(1'b1);
    chk("lat_busy", 16'(busy), 16'd1);
    chk("lat_score0", scoreBCD, 16'h0000);
    step();
    chk("lat_score1", scoreBCD, 16'h0001);
    chk("lat_busy_clr", 16'(busy), 16'd0);
    repeat (8) step();
    for (int i = 0; i < 4; i++) begin
      beat(1'b1);
      repeat (9) step();
    end
    chk("spaced_score", scoreBCD, 16'h0006);
    chk("spaced_streak", 16'(streak), 16'd5);
    chk("spaced_mult", 16'(multiplier), 16'd2);

    // Back-to-back hits: busy held through the drain, nothing lost
    do_start();
    chk("start_score", scoreBCD, 16'h0000);
    chk("start_mult", 16'(multiplier), 16'd1);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1);
      chk("b2b_busy_hit", 16'(busy), 16'd1);
    end
    step();
    chk("b2b_busy_drain", 16'(busy), 16'd1);
    chk("b2b_score_mid", scoreBCD, 16'h0005);
    step();
    chk("b2b_busy_done", 16'(busy), 16'd0);
    chk("b2b_score", scoreBCD, 16'h0006);

    // Miss during COUNT
    do_start();
    for (int i = 0; i < 5; i++) beat(1'b1);
    beat(1'b0);
    chk("miss_streak", 16'(streak), 16'd0);
    chk("miss_mult", 16'(multiplier), 16'd1);
    chk("miss_busy", 16'(busy), 16'd1);
    wait_idle("miss_drain", 10);
    chk("miss_score", scoreBCD, 16'h0006);

    // Multiplier cap: 4+8+12+16 = 40 points over 16 hits
    do_start();
    for (int i = 0; i < 12; i++) beat(1'b1);
    chk("cap12_streak", 16'(streak), 16'd12);
    chk("cap12_mult", 16'(multiplier), 16'd4);
    for (int i = 0; i < 4; i++) beat(1'b1);
    chk("cap16_streak", 16'(streak), 16'd16);
    chk("cap16_mult", 16'(multiplier), 16'd4);
    wait_idle("cap_drain", 100);
    chk("cap_score", scoreBCD, 16'h0040);

    // Saturation: 2600 more hits at x4, paced so pending never clips
    for (int i = 0; i < 2600; i++) begin
      beat(1'b1);
      repeat (3) step();
    end
    wait_idle("sat_drain", 300);
    chk("sat_score", scoreBCD, 16'h9999);
    chk("sat_streak", 16'(streak), 16'd255);
    chk("sat_mult", 16'(multiplier), 16'd4);
    beat(1'b1);
    chk("sat_busy_again", 16'(busy), 16'd1);
    wait_idle("sat_drain2", 20);
    chk("sat_hold", scoreBCD, 16'h9999);

    // songDone: drain first, later hit ignored, FINAL sticky
    do_start();
    beat(1'b1);
    beat(1'b1);
    end_song();
    chk("done_final_early", 16'(scoreFinal), 16'd0);
    chk("done_score_drain", scoreBCD, 16'h0002);
    beat(1'b1);
    chk("done_final", 16'(scoreFinal), 16'd1);
    chk("done_streak", 16'(streak), 16'd2);
    chk("done_busy", 16'(busy), 16'd0);
    repeat (3) step();
    chk("done_final_hold", 16'(scoreFinal), 16'd1);
    chk("done_score_hold", scoreBCD, 16'h0002);

    // start wins over a simultaneous changeScore
    start = 1'b1;
    changeScore = 1'b1;
    addScore = 1'b1;
    step();
    start = 1'b0;
    changeScore = 1'b0;
    addScore = 1'b0;
    chk("stcs_score", scoreBCD, 16'h0000);
    chk("stcs_streak", 16'(streak), 16'd0);
    chk("stcs_busy", 16'(busy), 16'd0);
    chk("stcs_final", 16'(scoreFinal), 16'd0);
    step();
    chk("stcs_score2", scoreBCD, 16'h0000);

    // High score across two songs (6 then 3)
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    high_exp = 16'h0006;
`else
    high_exp = 16'h0000;
`endif
    for (int i = 0; i < 5; i++) begin
      beat(1'b1);
      wait_idle("hs_a_drain", 10);
    end
    end_song();
    wait_final("hs_a_final", 10);
    chk("hs_a_score", scoreBCD, 16'h0006);
    chk("hs_a_high", highScoreBCD, high_exp);
    do_start();
    chk("hs_keep_on_start", highScoreBCD, high_exp);
    for (int i = 0; i < 3; i++) begin
      beat(1'b1);
      wait_idle("hs_b_drain", 10);
    end
    end_song();
    wait_final("hs_b_final", 10);
    chk("hs_b_score", scoreBCD, 16'h0003);
    chk("hs_b_high", highScoreBCD, high_exp);

    // Asynchronous reset in the middle of COUNT
    do_start();
    for (int i = 0; i < 5; i++) beat(1'b1);
    chk("ar_busy_before", 16'(busy), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("ar");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) step();
    chk("ar_score_after", scoreBCD, 16'h0000);
    chk("ar_busy_after", 16'(busy), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
